branch_resolve_q: RTL

// - In-order branch resolution queue: the update-side counterpart of the 2-bit PHT predictor.
// - Fetch allocates one entry per predicted branch (pc, prediction). Execute resolves entries
//   out of order by tag. Entries retire from the head in program order.
// - Each retirement drives the PHT training interface (update_valid/actual_taken/pc).
// - A retiring mispredict flushes the queue and redirects fetch.

---
 rtl/branch_resolve_q_if.sv | 37 +++
 rtl/branch_resolve_q.sv | 131 +++++++++++++
 2 files changed

// File: rtl/branch_resolve_q_if.sv
// Fetch/execute/predictor-facing bundle of the branch resolution queue.
// The slave modport is the queue side. The master modport is the fetch/execute/PHT side.
interface branch_resolve_q_if #(
   parameter int IDX_W = 8,
   parameter int DEPTH = 8
);
   localparam int TAG_W = $clog2(DEPTH);

   logic             alloc_valid;
   logic [IDX_W-1:0] alloc_pc;
   logic             alloc_pred;
   logic [IDX_W-1:0] alloc_target;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic             res_taken;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_pc;
   logic             upd_taken;
   logic             mispred_valid;
   logic [IDX_W-1:0] redirect_pc;
   logic [15:0]      stat_branches;
   logic [15:0]      stat_mispreds;

   modport master (
      output alloc_valid, alloc_pc, alloc_pred, alloc_target, res_valid, res_tag, res_taken,
      input  alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken, mispred_valid, redirect_pc,
             stat_branches, stat_mispreds
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_pred, alloc_target, res_valid, res_tag, res_taken,
      output alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken, mispred_valid, redirect_pc,
             stat_branches, stat_mispreds
   );
endinterface

// File: rtl/branch_resolve_q.sv
// In-order branch resolution queue. Entries are allocated at fetch and resolved out of order.
// They retire in order into PHT training, and a mispredict retirement flushes the queue. Optional stats: BRQ_STATS_EN.
module branch_resolve_q #(
   parameter int INSTR_MEM_IDX_W = 8,
   parameter int DEPTH           = 8
) (
   input logic clk,
   input logic rst_n,
   branch_resolve_q_if.slave bus
);
   localparam int IDX_W = INSTR_MEM_IDX_W;
   localparam int TAG_W = $clog2(DEPTH);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TAG_W:0]   ptr_t;

   logic [DEPTH-1:0] vld_q, vld_d, rsv_q, rsv_d;
   logic [DEPTH-1:0] pred_q, tkn_q;
   idx_t             pc_q  [DEPTH];
   idx_t             tgt_q [DEPTH];
   ptr_t             head_q, head_d, tail_q, tail_d;

   logic             upd_valid_q, upd_taken_q, mispred_valid_q;
   idx_t             upd_pc_q, redirect_pc_q;

   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             full, empty, retire, mispred, alloc_fire, res_fire;

   function automatic idx_t redirect_of(input logic taken, input idx_t pc, input idx_t tgt);
      return taken ? tgt : pc + idx_t'(1);
   endfunction

   assign head_idx   = head_q[TAG_W-1:0];
   assign tail_idx   = tail_q[TAG_W-1:0];
   assign full       = (head_q[TAG_W] != tail_q[TAG_W]) && (head_idx == tail_idx);
   assign empty      = (head_q == tail_q);
   assign retire     = !empty && vld_q[head_idx] && rsv_q[head_idx];
   assign mispred    = retire && (tkn_q[head_idx] != pred_q[head_idx]);
   // Fetch traffic in the cycle of a mispredict pop is wrong-path and is dropped
   assign alloc_fire = bus.alloc_valid && !full && !mispred;
   assign res_fire   = bus.res_valid && vld_q[bus.res_tag] && !rsv_q[bus.res_tag];

   assign bus.alloc_ready   = !full;
   assign bus.alloc_tag     = tail_idx;
   assign bus.upd_valid     = upd_valid_q;
   assign bus.upd_pc        = upd_pc_q;
   assign bus.upd_taken     = upd_taken_q;
   assign bus.mispred_valid = mispred_valid_q;
   assign bus.redirect_pc   = redirect_pc_q;

   always_comb begin
      vld_d  = vld_q;
      rsv_d  = rsv_q;
      head_d = head_q;
      tail_d = tail_q;
      if (res_fire) rsv_d[bus.res_tag] = 1'b1;
      if (alloc_fire) begin
         vld_d[tail_idx] = 1'b1;
         rsv_d[tail_idx] = 1'b0;
         tail_d          = tail_q + ptr_t'(1);
      end
      if (retire) begin
         vld_d[head_idx] = 1'b0;
         head_d          = head_q + ptr_t'(1);
      end
      // Flush overrides everything above, including same-cycle resolves of younger entries
      if (mispred) begin
         vld_d  = '0;
         tail_d = head_q + ptr_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         pc_q[tail_idx]   <= bus.alloc_pc;
         tgt_q[tail_idx]  <= bus.alloc_target;
         pred_q[tail_idx] <= bus.alloc_pred;
      end
      if (res_fire) tkn_q[bus.res_tag] <= bus.res_taken;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q           <= '0;
         rsv_q           <= '0;
         head_q          <= '0;
         tail_q          <= '0;
         upd_valid_q     <= 1'b0;
         upd_pc_q        <= '0;
         upd_taken_q     <= 1'b0;
         mispred_valid_q <= 1'b0;
         redirect_pc_q   <= '0;
      end else begin
         vld_q           <= vld_d;
         rsv_q           <= rsv_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         upd_valid_q     <= retire;
         mispred_valid_q <= mispred;
         if (retire) begin
            upd_pc_q    <= pc_q[head_idx];
            upd_taken_q <= tkn_q[head_idx];
         end
         if (mispred) redirect_pc_q <= redirect_of(tkn_q[head_idx], pc_q[head_idx], tgt_q[head_idx]);
      end
   end

`ifdef BRQ_STATS_EN
   logic [15:0] stat_br_q, stat_mis_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         if (retire)  stat_br_q  <= sat_inc(stat_br_q);
         if (mispred) stat_mis_q <= sat_inc(stat_mis_q);
      end
   end

   assign bus.stat_branches = stat_br_q;
   assign bus.stat_mispreds = stat_mis_q;
`else
   assign bus.stat_branches = 16'd0;
   assign bus.stat_mispreds = 16'd0;
`endif
endmodule
